// File: rtl/pcs_pkg.sv
// Shared PCS receive constants: sync header codes, block-lock state encoding,
// default lock/BER thresholds for 10G and 40G lanes.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [0:0] {
    TEST      = 1'b0,
    SLIP_WAIT = 1'b1
  } lock_state_e;

  localparam int PCS10_SH_CNT_N     = 64;
  localparam int PCS10_SH_INVLD_MAX = 16;
  localparam int PCS10_HI_BER_WIN_N = 3125;
  localparam int PCS10_HI_BER_TH    = 16;

  localparam int PCS40_SH_CNT_N     = 64;
  localparam int PCS40_SH_INVLD_MAX = 16;
  localparam int PCS40_HI_BER_WIN_N = 20000;
  localparam int PCS40_HI_BER_TH    = 97;

  function automatic logic hdr_good(input logic [1:0] head);
    return (head == SYNC_DATA) || (head == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/pcs_lock_lane.sv
// Single-lane sync-header block-lock FSM with gearbox slip request and an
// optional high-BER monitor (compiled in when PCS_HI_BER_EN is defined).
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   TEST      | counting headers in a window, deciding lock / slip
//   SLIP_WAIT | ignoring beats while the gearbox settles after a slip
module pcs_lock_lane
  import pcs_pkg::*;
#(
  parameter int SH_CNT_N     = PCS40_SH_CNT_N,
  parameter int SH_INVLD_MAX = PCS40_SH_INVLD_MAX,
  parameter int SLIP_WAIT_N  = 4,
  parameter int HI_BER_WIN_N = PCS40_HI_BER_WIN_N,
  parameter int HI_BER_TH    = PCS40_HI_BER_TH
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       v_i,
  input  logic [1:0] head_i,
  output logic       slip_o,
  output logic       block_lock_o,
  output logic       hi_ber_o
);

  localparam int WAIT_W = (SLIP_WAIT_N > 1) ? $clog2(SLIP_WAIT_N) : 1;
  localparam logic [0:0] ST_TEST      = TEST;
  localparam logic [0:0] ST_SLIP_WAIT = SLIP_WAIT;

  logic [0:0]        state_q, state_d;
  logic [6:0]        sh_cnt_q, sh_cnt_d;
  logic [4:0]        invld_cnt_q, invld_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              block_lock_q, block_lock_d;
  logic              slip_q, slip_d;

  logic       good;
  logic [6:0] sh_n;
  logic [4:0] inv_n;

  always_comb begin
    good         = hdr_good(head_i);
    sh_n         = sh_cnt_q + 7'd1;
    inv_n        = invld_cnt_q + {4'd0, ~good};
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    invld_cnt_d  = invld_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    block_lock_d = block_lock_q;
    slip_d       = 1'b0;
    if (v_i) begin
      case (state_q)
        ST_TEST: begin
          if (!good && (!block_lock_q || inv_n == 5'(SH_INVLD_MAX))) begin
            block_lock_d = 1'b0;
            slip_d       = 1'b1;
            sh_cnt_d     = '0;
            invld_cnt_d  = '0;
            wait_cnt_d   = '0;
            state_d      = ST_SLIP_WAIT;
          end else if (sh_n == 7'(SH_CNT_N)) begin
            // a clean window grants lock; a dirty one only keeps what we had
            if (inv_n == 5'd0) block_lock_d = 1'b1;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else begin
            sh_cnt_d    = sh_n;
            invld_cnt_d = inv_n;
          end
        end
        default: begin
          if (wait_cnt_q == WAIT_W'(SLIP_WAIT_N - 1)) begin
            state_d     = ST_TEST;
            wait_cnt_d  = '0;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_TEST;
      sh_cnt_q     <= '0;
      invld_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      block_lock_q <= 1'b0;
      slip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      invld_cnt_q  <= invld_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      block_lock_q <= block_lock_d;
      slip_q       <= slip_d;
    end
  end

  assign slip_o       = slip_q;
  assign block_lock_o = block_lock_q;

`ifdef PCS_HI_BER_EN
  localparam int BER_WIN_W = $clog2(HI_BER_WIN_N + 1);
  localparam int BER_CNT_W = $clog2(HI_BER_TH + 1);

  logic [BER_WIN_W-1:0] ber_win_q, ber_win_d, ber_win_n;
  logic [BER_CNT_W-1:0] ber_cnt_q, ber_cnt_d, ber_cnt_n;
  logic                 hi_ber_q, hi_ber_d;

  always_comb begin
    ber_win_n = ber_win_q + BER_WIN_W'(1);
    ber_cnt_n = ber_cnt_q;
    if (!good && ber_cnt_q != BER_CNT_W'(HI_BER_TH)) ber_cnt_n = ber_cnt_q + BER_CNT_W'(1);
    ber_win_d = ber_win_q;
    ber_cnt_d = ber_cnt_q;
    hi_ber_d  = hi_ber_q;
    if (!block_lock_d) begin
      ber_win_d = '0;
      ber_cnt_d = '0;
      hi_ber_d  = 1'b0;
    end else if (v_i && block_lock_q) begin
      if (ber_cnt_n >= BER_CNT_W'(HI_BER_TH)) hi_ber_d = 1'b1;
      if (ber_win_n == BER_WIN_W'(HI_BER_WIN_N)) begin
        hi_ber_d  = (ber_cnt_n >= BER_CNT_W'(HI_BER_TH));
        ber_win_d = '0;
        ber_cnt_d = '0;
      end else begin
        ber_win_d = ber_win_n;
        ber_cnt_d = ber_cnt_n;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ber_win_q <= '0;
      ber_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      ber_win_q <= ber_win_d;
      ber_cnt_q <= ber_cnt_d;
      hi_ber_q  <= hi_ber_d;
    end
  end

  assign hi_ber_o = hi_ber_q;
`else
  // BER monitor compiled out; output tied low
  localparam bit BER_CFG_OK = (HI_BER_TH > 0) && (HI_BER_WIN_N >= HI_BER_TH);
  assign hi_ber_o = BER_CFG_OK & 1'b0;
`endif

endmodule

// File: rtl/pcs_lock_ctrl.sv
// Multi-lane PCS receive block-lock controller with registered aggregate lock.
// Optional high-BER monitoring per lane is enabled by defining PCS_HI_BER_EN.
module pcs_lock_ctrl
  import pcs_pkg::*;
#(
  parameter int LANE_N       = 4,
  parameter int HEAD_W       = 2,
  parameter int SH_CNT_N     = PCS40_SH_CNT_N,
  parameter int SH_INVLD_MAX = PCS40_SH_INVLD_MAX,
  parameter int SLIP_WAIT_N  = 4,
  parameter int HI_BER_WIN_N = PCS40_HI_BER_WIN_N,
  parameter int HI_BER_TH    = PCS40_HI_BER_TH
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [LANE_N-1:0]        serdes_v_i,
  input  logic [LANE_N*HEAD_W-1:0] serdes_head_i,
  output logic [LANE_N-1:0]        gearbox_slip_o,
  output logic [LANE_N-1:0]        block_lock_o,
  output logic                     all_lock_o,
  output logic [LANE_N-1:0]        hi_ber_o
);

  logic all_lock_q, all_lock_d;

  for (genvar x = 0; x < LANE_N; x++) begin : g_lane
    pcs_lock_lane #(
      .SH_CNT_N     (SH_CNT_N),
      .SH_INVLD_MAX (SH_INVLD_MAX),
      .SLIP_WAIT_N  (SLIP_WAIT_N),
      .HI_BER_WIN_N (HI_BER_WIN_N),
      .HI_BER_TH    (HI_BER_TH)
    ) u_lane (
      .clk          (clk),
      .nreset       (nreset),
      .v_i          (serdes_v_i[x]),
      .head_i       (serdes_head_i[x*HEAD_W +: 2]),
      .slip_o       (gearbox_slip_o[x]),
      .block_lock_o (block_lock_o[x]),
      .hi_ber_o     (hi_ber_o[x])
    );
  end

  assign all_lock_d = &block_lock_o;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) all_lock_q <= 1'b0;
    else         all_lock_q <= all_lock_d;
  end

  assign all_lock_o = all_lock_q;

endmodule
